// File: rtl/gain_ramp_pkg.sv
// Shared types and constants for the gain ramp sequencer: FSM states,
// default settings-bus addresses and the Q16.16 fraction width.
package gain_ramp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_EOP = 2'd1,
      ST_RAMP     = 2'd2
   } state_t;

   localparam logic [7:0] SR_TARGET_DEF = 8'd192;
   localparam logic [7:0] SR_RAMP_DEF   = 8'd193;
   localparam int         FRAC_W        = 16;

endpackage

// File: rtl/gain_ramp_ctrl.sv
// Ramps the multiplier gain linearly to a settings-bus target over 2^k accepted beats.
// Latency: target write at t -> start at t+1; gain steps the cycle after each beat.
// Backpressure: gain holds without beats. GAIN_RAMP_SYNC_TLAST_EN defers starts to packet ends.
module gain_ramp_ctrl
   import gain_ramp_pkg::*;
#(
   parameter logic [7:0]  SR_TARGET  = SR_TARGET_DEF,
   parameter logic [7:0]  SR_RAMP    = SR_RAMP_DEF,
   parameter logic [15:0] GAIN_RESET = 16'h0000
) (
   input  logic        ce_clk,
   input  logic        ce_rst,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic        s_tvalid,
   input  logic        s_tready,
   input  logic        s_tlast,
   output logic [15:0] gain,
   output logic        busy,
   output logic        done_stb
);

   state_t             state, state_nxt;
   logic signed [31:0] acc, acc_nxt;
   logic signed [31:0] delta, delta_nxt;
   logic [15:0]        cnt, cnt_nxt;
   logic [15:0]        tgt_act, tgt_act_nxt;
   logic [15:0]        tgt_pend, tgt_pend_nxt;
   logic [3:0]         k, k_nxt;
   logic               pend, pend_nxt;
   logic               busy_nxt, done_nxt;
   logic               beat, wr_target, wr_ramp, start;
   logic signed [32:0] diff, diff_sh;
   logic               unused_bits;

   assign beat      = s_tvalid & s_tready;
   assign wr_target = set_stb && (set_addr == SR_TARGET);
   assign wr_ramp   = set_stb && (set_addr == SR_RAMP);
   assign gain      = acc[31:FRAC_W];

   // 33-bit difference so a full-scale swing cannot overflow before the shift.
   assign diff    = $signed({tgt_pend[15], tgt_pend, 16'h0000}) - $signed({acc[31], acc});
   assign diff_sh = diff >>> k;

`ifdef GAIN_RAMP_SYNC_TLAST_EN
   assign unused_bits = ^set_data[31:16];
`else
   assign unused_bits = ^{set_data[31:16], s_tlast};
`endif

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      delta_nxt    = delta;
      cnt_nxt      = cnt;
      tgt_act_nxt  = tgt_act;
      tgt_pend_nxt = tgt_pend;
      k_nxt        = k;
      pend_nxt     = pend;
      done_nxt     = 1'b0;
      start        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pend) begin
`ifdef GAIN_RAMP_SYNC_TLAST_EN
               state_nxt = ST_WAIT_EOP;
`else
               start = 1'b1;
`endif
            end
         end
`ifdef GAIN_RAMP_SYNC_TLAST_EN
         ST_WAIT_EOP: begin
            if (beat && s_tlast) start = 1'b1;
         end
`endif
         ST_RAMP: begin
            if (beat) begin
               acc_nxt = acc + delta;
               cnt_nxt = cnt - 16'd1;
               if (cnt == 16'd1) begin
                  // Snap to the exact target to drop accumulated truncation error.
                  acc_nxt   = {tgt_act, 16'h0000};
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (start) begin
         tgt_act_nxt = tgt_pend;
         pend_nxt    = 1'b0;
         if (k == 4'd0) begin
            acc_nxt   = {tgt_pend, 16'h0000};
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end else begin
            delta_nxt = diff_sh[31:0];
            cnt_nxt   = 16'd1 << k;
            state_nxt = ST_RAMP;
         end
      end

      // A write coinciding with a start lands after it, so it stays pending.
      if (wr_target) begin
         tgt_pend_nxt = set_data[15:0];
         pend_nxt     = 1'b1;
      end
      if (wr_ramp) k_nxt = set_data[3:0];

      busy_nxt = (state_nxt != ST_IDLE) || pend_nxt;
   end

   always_ff @(posedge ce_clk) begin
      if (ce_rst) begin
         state    <= ST_IDLE;
         acc      <= {GAIN_RESET, 16'h0000};
         delta    <= '0;
         cnt      <= '0;
         tgt_act  <= GAIN_RESET;
         tgt_pend <= GAIN_RESET;
         k        <= '0;
         pend     <= 1'b0;
         busy     <= 1'b0;
         done_stb <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         delta    <= delta_nxt;
         cnt      <= cnt_nxt;
         tgt_act  <= tgt_act_nxt;
         tgt_pend <= tgt_pend_nxt;
         k        <= k_nxt;
         pend     <= pend_nxt;
         busy     <= busy_nxt;
         done_stb <= done_nxt;
      end
   end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed self-checking bench for gain_ramp_ctrl; inputs driven and outputs
// sampled on the falling edge. Define GAIN_RAMP_SYNC_TLAST_EN to add the packet-sync test.
module tb_gain_ramp_ctrl;
   import gain_ramp_pkg::*;

   logic        ce_clk = 1'b0;
   logic        ce_rst;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic        s_tvalid, s_tready, s_tlast;
   logic [15:0] gain;
   logic        busy, done_stb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ce_clk = ~ce_clk;

   gain_ramp_ctrl dut (
      .ce_clk   (ce_clk),
      .ce_rst   (ce_rst),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tlast  (s_tlast),
      .gain     (gain),
      .busy     (busy),
      .done_stb (done_stb)
   );

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = {16'hABCD, d};
   endtask

   task automatic test_reset;
      ce_rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
      s_tvalid = 1'b0; s_tready = 1'b0; s_tlast = 1'b0;
      repeat (3) @(negedge ce_clk);
      ce_rst = 1'b0;
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0000) begin n_fail++; $display("FAIL reset_gain: got %h want %h", gain, 16'h0000); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done_stb !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_stb); end
   endtask

   task automatic test_k0;
      wr(SR_RAMP_DEF, 16'd0);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'h4000);
      @(negedge ce_clk);
      set_stb = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL k0_busy_t1: got %b want 1", busy); end
      n_checks++; if (gain !== 16'h0000) begin n_fail++; $display("FAIL k0_gain_t1: got %h want 0000", gain); end
      n_checks++; if (done_stb !== 1'b0) begin n_fail++; $display("FAIL k0_done_t1: got %b want 0", done_stb); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h4000) begin n_fail++; $display("FAIL k0_gain_t2: got %h want 4000", gain); end
      n_checks++; if (done_stb !== 1'b1) begin n_fail++; $display("FAIL k0_done_t2: got %b want 1", done_stb); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL k0_busy_t2: got %b want 0", busy); end
      @(negedge ce_clk);
      n_checks++; if (done_stb !== 1'b0) begin n_fail++; $display("FAIL k0_done_t3: got %b want 0", done_stb); end
      n_checks++; if (gain !== 16'h4000) begin n_fail++; $display("FAIL k0_gain_t3: got %h want 4000", gain); end
   endtask

   // Second write lands on the start cycle: start takes 0x1111, 0x2222 stays pending.
   task automatic test_back_to_back;
      wr(SR_TARGET_DEF, 16'h1111);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'h2222);
      n_checks++; if (gain !== 16'h4000) begin n_fail++; $display("FAIL b2b_gain_t1: got %h want 4000", gain); end
      @(negedge ce_clk);
      set_stb = 1'b0;
      n_checks++; if (gain !== 16'h1111) begin n_fail++; $display("FAIL b2b_gain_t2: got %h want 1111", gain); end
      n_checks++; if (done_stb !== 1'b1) begin n_fail++; $display("FAIL b2b_done_t2: got %b want 1", done_stb); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_t2: got %b want 1", busy); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h2222) begin n_fail++; $display("FAIL b2b_gain_t3: got %h want 2222", gain); end
      n_checks++; if (done_stb !== 1'b1) begin n_fail++; $display("FAIL b2b_done_t3: got %b want 1", done_stb); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_t3: got %b want 0", busy); end
      @(negedge ce_clk);
      n_checks++; if (done_stb !== 1'b0) begin n_fail++; $display("FAIL b2b_done_t4: got %b want 0", done_stb); end
   endtask

   task automatic test_ramp_k2;
      logic [15:0] eg [7] = '{16'h0000, 16'h0000, 16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1000};
      logic        ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic        eb [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ce_rst = 1'b1;
      @(negedge ce_clk);
      ce_rst = 1'b0;
      wr(SR_RAMP_DEF, 16'd2);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'h1000);
      s_tvalid = 1'b1; s_tready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge ce_clk);
         set_stb = 1'b0;
         n_checks++; if (gain !== eg[i]) begin n_fail++; $display("FAIL k2_gain[%0d]: got %h want %h", i, gain, eg[i]); end
         n_checks++; if (done_stb !== ed[i]) begin n_fail++; $display("FAIL k2_done[%0d]: got %b want %b", i, done_stb, ed[i]); end
         n_checks++; if (busy !== eb[i]) begin n_fail++; $display("FAIL k2_busy[%0d]: got %b want %b", i, busy, eb[i]); end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_negative_stall;
      wr(SR_RAMP_DEF, 16'd1);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'hF000);
      s_tvalid = 1'b1; s_tready = 1'b1;
      @(negedge ce_clk);
      set_stb = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL neg_busy_t1: got %b want 1", busy); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h1000) begin n_fail++; $display("FAIL neg_gain_t2: got %h want 1000", gain); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0000) begin n_fail++; $display("FAIL neg_gain_mid: got %h want 0000", gain); end
      s_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ce_clk);
         n_checks++; if (gain !== 16'h0000) begin n_fail++; $display("FAIL stall_gain[%0d]: got %h want 0000", i, gain); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy[%0d]: got %b want 1", i, busy); end
         n_checks++; if (done_stb !== 1'b0) begin n_fail++; $display("FAIL stall_done[%0d]: got %b want 0", i, done_stb); end
      end
      s_tready = 1'b1;
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'hF000) begin n_fail++; $display("FAIL neg_gain_end: got %h want F000", gain); end
      n_checks++; if (done_stb !== 1'b1) begin n_fail++; $display("FAIL neg_done_end: got %b want 1", done_stb); end
      s_tvalid = 1'b0;
   endtask

   // k=3 ramp F000->0800 with 0x2000 then 0x3000 written mid-ramp.
   task automatic test_retarget;
      logic [15:0] eg [20] = '{16'hF000, 16'hF000, 16'hF300, 16'hF600, 16'hF900, 16'hFC00, 16'hFF00,
                               16'h0200, 16'h0500, 16'h0800, 16'h0800, 16'h0D00, 16'h1200, 16'h1700,
                               16'h1C00, 16'h2100, 16'h2600, 16'h2B00, 16'h3000, 16'h3000};
      logic        ed;
      logic        eb;
      wr(SR_RAMP_DEF, 16'd3);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'h0800);
      s_tvalid = 1'b1; s_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge ce_clk);
         set_stb = 1'b0;
         if (i == 2) wr(SR_TARGET_DEF, 16'h2000);
         if (i == 3) wr(SR_TARGET_DEF, 16'h3000);
         ed = (i == 9) || (i == 18);
         eb = (i < 18);
         n_checks++; if (gain !== eg[i]) begin n_fail++; $display("FAIL retgt_gain[%0d]: got %h want %h", i, gain, eg[i]); end
         n_checks++; if (done_stb !== ed) begin n_fail++; $display("FAIL retgt_done[%0d]: got %b want %b", i, done_stb, ed); end
         n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL retgt_busy[%0d]: got %b want %b", i, busy, eb); end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_reset_mid_ramp;
      wr(SR_RAMP_DEF, 16'd2);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'h2000);
      s_tvalid = 1'b1; s_tready = 1'b1;
      @(negedge ce_clk);
      set_stb = 1'b0;
      repeat (3) @(negedge ce_clk);
      n_checks++; if (gain !== 16'h2800) begin n_fail++; $display("FAIL rstmid_gain_pre: got %h want 2800", gain); end
      ce_rst = 1'b1;
      @(negedge ce_clk);
      ce_rst = 1'b0;
      n_checks++; if (gain !== 16'h0000) begin n_fail++; $display("FAIL rstmid_gain: got %h want 0000", gain); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_checks++; if (done_stb !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done_stb); end
      for (int i = 0; i < 4; i++) begin
         @(negedge ce_clk);
         n_checks++; if (gain !== 16'h0000 || done_stb !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold[%0d]: got %h/%b want 0000/0", i, gain, done_stb); end
      end
      wr(SR_RAMP_DEF, 16'd1);
      @(negedge ce_clk);
      wr(SR_TARGET_DEF, 16'h0200);
      @(negedge ce_clk);
      set_stb = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rearm_busy: got %b want 1", busy); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0000) begin n_fail++; $display("FAIL rstmid_r0: got %h want 0000", gain); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0100) begin n_fail++; $display("FAIL rstmid_r1: got %h want 0100", gain); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0200 || done_stb !== 1'b1) begin n_fail++; $display("FAIL rstmid_r2: got %h/%b want 0200/1", gain, done_stb); end
      @(negedge ce_clk);
      n_checks++; if (done_stb !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_r3: got done %b busy %b want 0/0", done_stb, busy); end
      s_tvalid = 1'b0;
   endtask

`ifdef GAIN_RAMP_SYNC_TLAST_EN
   task automatic test_sync_tlast;
      s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = 1'b0;
      wr(SR_TARGET_DEF, 16'h0600);
      for (int i = 0; i < 4; i++) begin
         @(negedge ce_clk);
         set_stb = 1'b0;
         n_checks++; if (gain !== 16'h0200 || busy !== 1'b1) begin n_fail++; $display("FAIL sync_wait[%0d]: got %h/%b want 0200/1", i, gain, busy); end
      end
      s_tlast = 1'b1;
      @(negedge ce_clk);
      s_tlast = 1'b0;
      n_checks++; if (gain !== 16'h0200) begin n_fail++; $display("FAIL sync_eop: got %h want 0200", gain); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0400) begin n_fail++; $display("FAIL sync_step1: got %h want 0400", gain); end
      @(negedge ce_clk);
      n_checks++; if (gain !== 16'h0600 || done_stb !== 1'b1) begin n_fail++; $display("FAIL sync_step2: got %h/%b want 0600/1", gain, done_stb); end
      s_tvalid = 1'b0;
   endtask
`endif

   initial begin
      test_reset;
      test_k0;
      test_back_to_back;
      test_ramp_k2;
      test_negative_stall;
      test_retarget;
      test_reset_mid_ramp;
`ifdef GAIN_RAMP_SYNC_TLAST_EN
      test_sync_tlast;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gain_ramp_ctrl.md
# gain_ramp_ctrl

Sequencer for the gain multiplier in the gain compute engine. It takes gain targets from the settings bus and ramps the gain presented to the real input of the complex×real multiplier linearly over 2^k accepted samples. Gain changes are aligned to sample handshakes, so every sample is multiplied by exactly one gain value. The block sits between the settings bus and the multiplier's real operand and replaces the plain gain setting register.

## Interface
- `SR_TARGET`, 192: settings address of the target gain. A write arms a ramp.
- `SR_RAMP`, 193: settings address of the ramp length exponent k (`set_data[3:0]`).
- `GAIN_RESET`, 16'h0000: gain value out of reset.
- `ce_clk` in 1: clock. The block uses one clock.
- `ce_rst` in 1: reset, synchronous, active-high.
- `set_stb` in 1: settings write strobe.
- `set_addr` in 8: settings address.
- `set_data` in 32: settings data. The gain is taken from `[15:0]`, signed.
- `s_tvalid` in 1: monitored sample stream into the multiplier, valid.
- `s_tready` in 1: monitored sample stream, ready. A beat is `s_tvalid & s_tready`.
- `s_tlast` in 1: monitored sample stream, end of packet.
- `gain` out 16: signed gain to the multiplier real operand. Registered.
- `busy` out 1: high while in WAIT_EOP or RAMP, or while a target is pending.
- `done_stb` out 1: one-cycle pulse when a ramp completes.

## Operation
- Internal state:
  - `acc`: 32-bit signed, Q16.16. `gain = acc[31:16]`.
  - `delta`: 32-bit signed.
  - `cnt`: 16 bits.
  - `k`: 4 bits.
  - `tgt_act` and `tgt_pend`: 16 bits each.
  - `pend` flag.
- Writing `SR_RAMP` updates `k` only. A ramp already in progress keeps the `k` it latched at start.
- Writing `SR_TARGET` sets `tgt_pend = set_data[15:0]` and `pend = 1`. A later write overwrites an earlier pending one; the last write wins.
- States:
  - IDLE: if `pend` is set, the block takes a start event (or goes to WAIT_EOP when the sync feature is compiled in).
  - WAIT_EOP: waits for a beat with `s_tlast = 1`, then takes a start event.
  - RAMP: on each beat, `acc += delta` and `cnt--`.
    - On the beat where `cnt == 1`: set `acc = tgt_act << 16`, pulse `done_stb`, and leave RAMP.
    - The next state is IDLE. Because `pend` may be set, IDLE then re-arms in the following cycle.
- Start event:
  - `tgt_act = tgt_pend` and `pend = 0`. `k` is latched.
  - If `k == 0`: `acc = tgt_act << 16`, `done_stb` pulses, and the state becomes IDLE.
  - Otherwise: `delta = ((tgt_act << 16) − acc) >>> k`, computed as a 33-bit difference then shifted arithmetically. `cnt = 2^k`. The state becomes RAMP.
- Arithmetic:
  - The shift rounds toward −∞.
  - The final snap to `tgt_act << 16` removes accumulated truncation error, so the end gain always equals the target exactly.
  - `acc` never leaves the signed range between the start value and the target, so no saturation is needed.
- Backpressure: without beats, `gain`, `cnt` and `acc` hold indefinitely.
- Simultaneous events:
  - A target write in the same cycle as the final RAMP beat: the ramp finishes to the old `tgt_act`, and the new target stays pending.
  - A target write in the same cycle as a start event: the start uses the old `tgt_pend`, and `pend` stays set with the new value.
- Reset, at any time including mid-ramp:
  - `gain = GAIN_RESET` and `acc = GAIN_RESET << 16`.
  - State IDLE; `pend`, `k`, `cnt` and `delta` all 0.
  - `tgt_act = tgt_pend = GAIN_RESET`.
  - `busy = 0` and `done_stb = 0`.

## Timing
- `set_stb` at cycle t: `pend` is visible at t+1, and the start event happens in IDLE at t+1 at the earliest.
- k = 0: `gain` equals the target at t+2, and `done_stb` is high during t+2.
- k > 0: `gain` updates in the cycle after each beat. After 2^k beats, `gain` equals the target and `done_stb` pulses in the same cycle as that final gain.
- The multiplier samples `gain` on the beat. Because the gain changes only after a beat, each sample sees a single gain value.
- `busy` is registered and asserts at t+1 after a target write.

## Configuration
- `GAIN_RAMP_SYNC_TLAST_EN`:
  - Defined: a pending target in IDLE moves to WAIT_EOP. The ramp starts in the cycle after the first beat with `s_tlast = 1`, so gain changes begin on a packet boundary.
  - Undefined: the WAIT_EOP state is not compiled in, and the start event happens directly in IDLE.

## Structure
- Shared package (`gain_ramp_pkg`):
  - State enum (IDLE, WAIT_EOP, RAMP).
  - Default values for `SR_TARGET` and `SR_RAMP`.
  - Q16.16 fraction width constant (16).
- Sub-module: none. The settings decode is two address compares and stays inline.

## Test plan
1. k = 0, target 0x4000 written at t: `gain` = 0x4000 at t+2, and `done_stb` pulses once at t+2.
2. Gain 0, k = 2, target 0x1000, continuous beats: `gain` steps 0x0400, 0x0800, 0x0C00, 0x1000, and `done_stb` pulses with 0x1000.
3. k = 1, from 0x1000 to 0xF000 (−4096): `gain` = 0x0000 then 0xF000. Then drop `s_tready` for 10 cycles mid-ramp: `gain` holds and `busy` stays 1.
4. During a k = 3 ramp to 0x0800, write 0x2000 then 0x3000: the first ramp ends exactly at 0x0800, then a new ramp to 0x3000 starts in the next IDLE cycle; 0x2000 never appears.
5. Assert `ce_rst` mid-ramp: the next cycle shows `gain` = `GAIN_RESET`, `busy` = 0, and no `done_stb`. A later target write ramps normally.
6. With `GAIN_RAMP_SYNC_TLAST_EN`, write a target mid-packet: `gain` stays unchanged through the remaining beats and steps only on the first beat after the `s_tlast` beat.
